// File: rtl/car_renderer.sv
// Pixel generator for the race game: background fill, car sprite, erase and crash redraw.
// Optional wall-overlap detection is built when CAR_RENDERER_HITWALL_EN is defined.
module car_renderer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CAR_W = 8,
  parameter int CAR_H = 8,
  parameter logic [2:0] TRANSPARENT = 3'b000,
  parameter logic [2:0] WALL_COLOUR = 3'b100,
  parameter logic [2:0] CRASH_COLOUR = 3'b110
) (
  input  logic Clock,
  input  logic Reset,
  input  logic draw_background,
  input  logic draw_car,
  input  logic draw_over_car,
  input  logic draw_fix_car,
  input  logic [7:0] car_x,
  input  logic [6:0] car_y,
  output logic [14:0] bg_addr,
  input  logic [2:0] bg_data,
  output logic [$clog2(CAR_W*CAR_H)-1:0] spr_addr,
  input  logic [2:0] spr_data,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic vga_plot,
  output logic DoneDrawBackground,
  output logic DoneDrawCar,
  output logic DoneDrawOverCar,
  output logic DoneFixCar,
  output logic HitWall
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BG    = 3'd1;
  localparam logic [2:0] S_CAR   = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;
  localparam logic [2:0] S_FIX   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] OP_BG   = 2'd0;
  localparam logic [1:0] OP_CAR  = 2'd1;
  localparam logic [1:0] OP_OVER = 2'd2;
  localparam logic [1:0] OP_FIX  = 2'd3;

  localparam int CCB = $clog2(CAR_W);
  localparam int CRB = $clog2(CAR_H);
  localparam logic [7:0] BG_LAST_X  = 8'(SCREEN_W - 1);
  localparam logic [6:0] BG_LAST_Y  = 7'(SCREEN_H - 1);
  localparam logic [7:0] CAR_LAST_X = 8'(CAR_W - 1);
  localparam logic [6:0] CAR_LAST_Y = 7'(CAR_H - 1);

  logic [2:0] state;
  logic [1:0] op;
  logic [7:0] col;
  logic [6:0] row;
  logic       drain_cnt;
  logic       active_req, drawing, abort, bg_used;
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [8:0] cx_p0;
  logic [7:0] cy_p0;
  logic       in_range_p0;

  logic       vld_p1;
  logic [1:0] op_p1;
  logic [7:0] x_p1;
  logic [6:0] y_p1;
  logic       in_range_p1;
  logic       opaque_p1, plot_p1;
  logic [2:0] colour_p1;

  // Fast path relies on 160 = 128 + 32; other widths fall back to a multiply.
  function automatic logic [14:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    logic [14:0] yw, xw;
    yw = 15'(y);
    xw = 15'(x);
    if (SCREEN_W == 160) pix_addr = (yw << 7) + (yw << 5) + xw;
    else                 pix_addr = yw * 15'(SCREEN_W) + xw;
  endfunction

  always_comb begin
    active_req = 1'b0;
    case (op)
      OP_BG:   active_req = draw_background;
      OP_CAR:  active_req = draw_car;
      OP_OVER: active_req = draw_over_car;
      default: active_req = draw_fix_car;
    endcase
  end

  assign drawing = (state == S_BG) || (state == S_CAR) || (state == S_OVER) || (state == S_FIX);
  assign abort   = (drawing || (state == S_DRAIN)) && !active_req;
  assign last_x  = (state == S_BG) ? BG_LAST_X : CAR_LAST_X;
  assign last_y  = (state == S_BG) ? BG_LAST_Y : CAR_LAST_Y;

  // Stage 0: counters form the screen coordinate and the ROM addresses
  assign cx_p0 = (state == S_BG) ? {1'b0, col} : {1'b0, car_x} + {1'b0, col};
  assign cy_p0 = (state == S_BG) ? {1'b0, row} : {1'b0, car_y} + {1'b0, row};
  assign in_range_p0 = (cx_p0 < 9'(SCREEN_W)) && (cy_p0 < 8'(SCREEN_H));

`ifdef CAR_RENDERER_HITWALL_EN
  assign bg_used = (state == S_BG) || (state == S_CAR) || (state == S_OVER);
`else
  assign bg_used = (state == S_BG) || (state == S_OVER);
`endif
  assign bg_addr  = bg_used ? pix_addr(cx_p0, cy_p0) : 15'd0;
  assign spr_addr = {row[CRB-1:0], col[CCB-1:0]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      op <= OP_BG;
      col <= '0;
      row <= '0;
      drain_cnt <= 1'b0;
      DoneDrawBackground <= 1'b0;
      DoneDrawCar <= 1'b0;
      DoneDrawOverCar <= 1'b0;
      DoneFixCar <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          col <= '0;
          row <= '0;
          if (draw_background)    begin state <= S_BG;   op <= OP_BG;   end
          else if (draw_car)      begin state <= S_CAR;  op <= OP_CAR;  end
          else if (draw_over_car) begin state <= S_OVER; op <= OP_OVER; end
          else if (draw_fix_car)  begin state <= S_FIX;  op <= OP_FIX;  end
        end
        S_BG, S_CAR, S_OVER, S_FIX: begin
          if (abort) state <= S_IDLE;
          else if (col == last_x) begin
            col <= '0;
            if (row == last_y) begin
              state <= S_DRAIN;
              drain_cnt <= 1'b0;
            end else row <= row + 7'd1;
          end else col <= col + 8'd1;
        end
        S_DRAIN: begin
          if (abort) state <= S_IDLE;
          else if (drain_cnt) begin
            state <= S_DONE;
            case (op)
              OP_BG:   DoneDrawBackground <= 1'b1;
              OP_CAR:  DoneDrawCar <= 1'b1;
              OP_OVER: DoneDrawOverCar <= 1'b1;
              default: DoneFixCar <= 1'b1;
            endcase
          end else drain_cnt <= 1'b1;
        end
        S_DONE: begin
          if (!active_req) begin
            state <= S_IDLE;
            DoneDrawBackground <= 1'b0;
            DoneDrawCar <= 1'b0;
            DoneDrawOverCar <= 1'b0;
            DoneFixCar <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: ROM data arrives, pixel colour and plot decision are selected
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) vld_p1 <= 1'b0;
    else       vld_p1 <= drawing && !abort;
  end

  always_ff @(posedge Clock) begin
    op_p1 <= op;
    x_p1 <= cx_p0[7:0];
    y_p1 <= cy_p0[6:0];
    in_range_p1 <= in_range_p0;
  end

  assign opaque_p1 = (spr_data != TRANSPARENT);

  always_comb begin
    colour_p1 = bg_data;
    plot_p1 = in_range_p1;
    case (op_p1)
      OP_BG:   begin colour_p1 = bg_data;      plot_p1 = 1'b1; end
      OP_CAR:  begin colour_p1 = spr_data;     plot_p1 = in_range_p1 && opaque_p1; end
      OP_OVER: begin colour_p1 = bg_data;      plot_p1 = in_range_p1; end
      default: begin colour_p1 = CRASH_COLOUR; plot_p1 = in_range_p1 && opaque_p1; end
    endcase
  end

  // Stage 2: registered VGA write port
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vga_plot <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= vld_p1 && plot_p1 && !abort;
      if (vld_p1) begin
        vga_x <= x_p1;
        vga_y <= y_p1;
        vga_colour <= colour_p1;
      end
    end
  end

`ifdef CAR_RENDERER_HITWALL_EN
  logic hit_sticky;

  // The sticky bit settles one edge before DRAIN hands over to DONE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hit_sticky <= 1'b0;
      HitWall <= 1'b0;
    end else begin
      if ((state == S_IDLE) && !draw_background && draw_car) hit_sticky <= 1'b0;
      else if (vld_p1 && (op_p1 == OP_CAR) && in_range_p1 && opaque_p1 && (bg_data == WALL_COLOUR))
        hit_sticky <= 1'b1;
      if ((state == S_DRAIN) && !abort && drain_cnt && (op == OP_CAR)) HitWall <= hit_sticky;
    end
  end
`else
  assign HitWall = 1'b0;
`endif

endmodule

// File: tb/tb_car_renderer.sv
// Directed bench for car_renderer: table of sprite draws plus background, abort and reset sequences.
module tb_car_renderer;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic draw_background = 1'b0, draw_car = 1'b0, draw_over_car = 1'b0, draw_fix_car = 1'b0;
  logic [7:0] car_x = 8'd0;
  logic [6:0] car_y = 7'd0;
  logic [14:0] bg_addr;
  logic [2:0] bg_data = 3'd0;
  logic [5:0] spr_addr;
  logic [2:0] spr_data = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot;
  logic DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneFixCar, HitWall;

`ifdef CAR_RENDERER_HITWALL_EN
  localparam bit HW_EN = 1'b1;
`else
  localparam bit HW_EN = 1'b0;
`endif

  car_renderer dut (
    .Clock(Clock), .Reset(Reset),
    .draw_background(draw_background), .draw_car(draw_car),
    .draw_over_car(draw_over_car), .draw_fix_car(draw_fix_car),
    .car_x(car_x), .car_y(car_y),
    .bg_addr(bg_addr), .bg_data(bg_data),
    .spr_addr(spr_addr), .spr_data(spr_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .DoneDrawBackground(DoneDrawBackground), .DoneDrawCar(DoneDrawCar),
    .DoneDrawOverCar(DoneDrawOverCar), .DoneFixCar(DoneFixCar),
    .HitWall(HitWall)
  );

  always #5 Clock = ~Clock;

  logic [2:0] bg_rom [0:19199];
  logic [2:0] spr_rom [0:63];

  always @(posedge Clock) begin
    bg_data <= (bg_addr < 15'd19200) ? bg_rom[bg_addr] : 3'd0;
    spr_data <= spr_rom[spr_addr];
  end

  typedef struct { int x; int y; int c; int t; } pix_t;
  typedef struct { int op; int px; int py; bit hit; int plots; } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit capture = 1'b0;
  bit exp_hw = 1'b0;
  pix_t got_q[$];

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    pix_t p;
    if (capture && vga_plot) begin
      p.x = int'(vga_x); p.y = int'(vga_y); p.c = int'(vga_colour); p.t = cyc;
      got_q.push_back(p);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int op, input logic v);
    case (op)
      0: draw_background = v;
      1: draw_car = v;
      2: draw_over_car = v;
      default: draw_fix_car = v;
    endcase
  endtask

  function automatic logic done_of(input int op);
    case (op)
      0: return DoneDrawBackground;
      1: return DoneDrawCar;
      2: return DoneDrawOverCar;
      default: return DoneFixCar;
    endcase
  endfunction

  task automatic fill_bg(input bit with_wall);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        bg_rom[y*160+x] = with_wall ? 3'((x ^ y) & 3) : 3'((x ^ y) & 7);
    if (with_wall) bg_rom[22*160+12] = 3'b100;
  endtask

  // op: 0 background, 1 car, 2 over_car, 3 fix_car
  task automatic run_op(input int op, input int px, input int py, input bit car_hit,
                        input int hand_plots, input string name);
    pix_t exp_q[$];
    pix_t p;
    int n_slots, req_cyc, done_cyc, bad;
    bit got_done;
    logic [3:0] exp_d;
    if (op == 0) begin
      for (int y = 0; y < 120; y++)
        for (int x = 0; x < 160; x++) begin
          p.x = x; p.y = y; p.c = int'(bg_rom[y*160+x]); p.t = y*160+x;
          exp_q.push_back(p);
        end
    end else begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          int x, y;
          logic [2:0] s;
          x = px + c; y = py + r; s = spr_rom[r*8+c];
          p.x = x; p.y = y; p.t = r*8+c;
          if (x < 160 && y < 120) begin
            if (op == 1 && s != 3'd0) begin p.c = int'(s); exp_q.push_back(p); end
            else if (op == 2) begin p.c = int'(bg_rom[y*160+x]); exp_q.push_back(p); end
            else if (op == 3 && s != 3'd0) begin p.c = 6; exp_q.push_back(p); end
          end
        end
    end
    n_slots = (op == 0) ? 19200 : 64;
    got_q.delete();
    @(posedge Clock); #1;
    car_x = 8'(px); car_y = 7'(py);
    capture = 1'b1;
    req_cyc = cyc;
    set_req(op, 1'b1);
    got_done = 1'b0; done_cyc = 0;
    for (int i = 0; i < n_slots + 40; i++) begin
      @(negedge Clock);
      if (done_of(op)) begin got_done = 1'b1; done_cyc = cyc; break; end
    end
    capture = 1'b0;
    check({name, "_done_seen"}, got_done, 1);
    check({name, "_plot_count"}, got_q.size(), hand_plots);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c ||
          got_q[i].t - req_cyc - 3 != exp_q[i].t) bad++;
    if (got_q.size() != exp_q.size()) bad++;
    check({name, "_pixel_errors"}, bad, 0);
    if (got_done) check({name, "_done_cycle"}, done_cyc - req_cyc, n_slots + 3);
    exp_d = 4'b1000 >> op;
    check({name, "_done_flags"}, {DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneFixCar}, exp_d);
    if (op == 1) exp_hw = car_hit & HW_EN;
    check({name, "_hitwall"}, HitWall, exp_hw);
    repeat (3) @(negedge Clock);
    check({name, "_done_held"}, done_of(op), got_done);
    @(posedge Clock); #1;
    set_req(op, 1'b0);
    @(posedge Clock); @(negedge Clock);
    check({name, "_done_clear"}, {DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneFixCar}, 0);
    check({name, "_hitwall_hold"}, HitWall, exp_hw);
  endtask

  initial begin
    vec_t vecs[9];
    int n, d;
    vecs[0] = '{1, 10, 20, 1'b1, 48};
    vecs[1] = '{1, 40, 40, 1'b0, 48};
    vecs[2] = '{1, 12, 22, 1'b0, 48};
    vecs[3] = '{1, 156, 116, 1'b0, 12};
    vecs[4] = '{2, 10, 20, 1'b0, 64};
    vecs[5] = '{3, 10, 20, 1'b0, 48};
    vecs[6] = '{2, 156, 116, 1'b0, 16};
    vecs[7] = '{3, 156, 116, 1'b0, 12};
    vecs[8] = '{1, 10, 20, 1'b1, 48};

    for (int i = 0; i < 64; i++) spr_rom[i] = (i % 4 == 0) ? 3'd0 : 3'((i % 7) + 1);
    fill_bg(1'b0);

    repeat (3) @(posedge Clock);
    #1;
    check("reset_plot", vga_plot, 0);
    check("reset_xyc", {vga_x, vga_y, vga_colour}, 0);
    check("reset_done", {DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneFixCar}, 0);
    check("reset_hitwall", HitWall, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    check("idle_plot", vga_plot, 0);
    check("idle_bg_addr", bg_addr, 0);

    run_op(0, 0, 0, 1'b0, 19200, "bg_fill");

    fill_bg(1'b1);
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].px, vecs[i].py, vecs[i].hit, vecs[i].plots, $sformatf("vec%0d", i));

    // abort a car draw after ten pixel slots
    @(posedge Clock); #1;
    car_x = 8'd40; car_y = 7'd40; draw_car = 1'b1;
    repeat (12) @(posedge Clock);
    #1 draw_car = 1'b0;
    @(negedge Clock);
    check("abort_last_plot", vga_plot, 1);
    @(negedge Clock);
    check("abort_plot_low", vga_plot, 0);
    n = 0; d = 0;
    repeat (40) begin
      @(negedge Clock);
      if (vga_plot) n++;
      if (DoneDrawCar) d++;
    end
    check("abort_no_plots", n, 0);
    check("abort_no_done", d, 0);
    check("abort_hitwall", HitWall, exp_hw);

    // asynchronous reset in the middle of a background fill
    fill_bg(1'b0);
    @(posedge Clock); #1;
    draw_background = 1'b1;
    repeat (50) @(posedge Clock);
    #1;
    check("bg_running", vga_plot, 1);
    #1 Reset = 1'b1;
    #1;
    check("rst_async_plot", vga_plot, 0);
    check("rst_async_xyc", {vga_x, vga_y, vga_colour}, 0);
    check("rst_async_flags", {DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneFixCar, HitWall}, 0);
    draw_background = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    exp_hw = 1'b0;
    run_op(0, 0, 0, 1'b0, 19200, "bg_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
